spi_print_tx: RTL and testbench

- Byte-serial debug-print transmitter inside the user project, driven by the core's MMIO print port.
- Buffers characters in a small FIFO and shifts each one out MSB-first on a clock/data pin pair, mprj_io[4] (sclk) and mprj_io[1] (mosi).
- The line has no chip select. The receiver samples mosi on the rising edge of sclk and frames purely by counting 8 rising edges per byte.

---
 rtl/spi_print_pkg.sv | 12 +
 rtl/spi_print_fifo.sv | 46 ++++
 rtl/spi_print_tx.sv | 134 +++++++++++++
 tb/tb_spi_print_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_print_pkg.sv
// rtl/spi_print_pkg.sv - shared types and constants for the debug-print SPI transmitter
package spi_print_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CLK_DIV    = 2;

endpackage

// File: rtl/spi_print_fifo.sv
// rtl/spi_print_fifo.sv - synchronous FIFO with extra-MSB pointers for full/empty
module spi_print_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i && !full_o) wptr_d = wptr_q + (AW+1)'(1);
    if (pop_i && !empty_o) rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_print_tx.sv
// rtl/spi_print_tx.sv - MMIO debug-print byte transmitter on an sclk/mosi pin pair
// Optional CR-before-LF expansion is enabled by defining SPI_PRINT_CRLF_EN.
module spi_print_tx
  import spi_print_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IN_valid,
  input  logic [7:0] IN_data,
  output logic       OUT_ready,
  output logic       OUT_sclk,
  output logic       OUT_mosi,
  output logic       OUT_busy
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          load;
  logic          lf_next;
  logic [7:0]    load_byte;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;

  spi_print_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (IN_valid),
    .wdata_i(IN_data),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

`ifdef SPI_PRINT_CRLF_EN
  // An LF from the FIFO goes out as CR first; the LF follows from the flag without a pop.
  logic lf_pend_q, lf_pend_d;
  assign lf_next   = lf_pend_q;
  assign load_byte = lf_pend_q ? CHAR_LF : ((fifo_rdata == CHAR_LF) ? CHAR_CR : fifo_rdata);
  assign lf_pend_d = load ? (!lf_pend_q && (fifo_rdata == CHAR_LF)) : lf_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lf_pend_q <= 1'b0;
    else        lf_pend_q <= lf_pend_d;
  end
`else
  assign lf_next   = 1'b0;
  assign load_byte = fifo_rdata;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    load    = 1'b0;
    case (state_q)
      IDLE: load = !fifo_empty;
      LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            mosi_d  = shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
            state_d = LOW;
          end else if (lf_next || !fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A load in HIGH chains the next byte straight into LOW, so bursts have no gap.
    if (load) begin
      state_d = LOW;
      div_d   = '0;
      bit_d   = 3'd7;
      mosi_d  = load_byte[7];
      shift_d = load_byte[6:0];
    end
  end

  assign fifo_pop = load && !lf_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign OUT_sclk  = sclk_q;
  assign OUT_mosi  = mosi_q;
  assign OUT_busy  = (state_q != IDLE) || !fifo_empty;
  assign OUT_ready = !fifo_full;

endmodule

// File: tb/tb_spi_print_tx.sv
// tb/tb_spi_print_tx.sv - scoreboard bench for spi_print_tx with randomized traffic
module tb_spi_print_tx;
  localparam int CD = 2;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
`ifdef SPI_PRINT_CRLF_EN
  localparam int CRLF = 1;
`else
  localparam int CRLF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ready, sclk, mosi, busy;
  logic       in1_valid = 1'b0;
  logic [7:0] in1_data = 8'h00;
  logic       ready1, sclk1, mosi1, busy1;

  spi_print_tx #(.FIFO_DEPTH(4), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .IN_valid(in_valid), .IN_data(in_data),
    .OUT_ready(ready), .OUT_sclk(sclk), .OUT_mosi(mosi), .OUT_busy(busy)
  );

  spi_print_tx #(.FIFO_DEPTH(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .IN_valid(in1_valid), .IN_data(in1_data),
    .OUT_ready(ready1), .OUT_sclk(sclk1), .OUT_mosi(mosi1), .OUT_busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         busy_fall = 0;
  int         last_acc = 0;
  int         exp1_bits[$];
  int         rise1_last = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nw(input logic [7:0] b);
    return (CRLF != 0 && b == LF) ? 2 : 1;
  endfunction

  // Reference model: each accepted character becomes one wire byte, or CR+LF for LF when expanded.
  task automatic model_push(input logic [7:0] b);
    if (nw(b) == 2) exp_q.push_back(CR);
    exp_q.push_back(b);
  endtask

  // Called at a negedge; leaves IN_valid high so callers can chain pushes back-to-back.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    while (!ready && n < 400) begin
      in_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    in_data = b;
    if (!ready) chk("send_timeout", 0, 1);
    else begin
      model_push(b);
      last_acc = cyc + 1;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, (busy || exp_q.size() != 0) ? 1 : 0, 0);
    @(negedge clk);
  endtask

  // Receiver-style monitor: sample mosi on each sclk rise, frame by counting 8 rises.
  initial begin
    logic [7:0] sh = 8'h00;
    int         nb = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0;
        prev_sclk = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (sclk && !prev_sclk) begin
          rise_q.push_back(cyc);
          sh = {sh[6:0], mosi};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (exp_q.size() == 0) chk("extra_byte", int'(sh), -1);
            else chk("byte", int'(sh), int'(exp_q.pop_front()));
          end
        end
        if (prev_busy && !busy) busy_fall = cyc;
        prev_sclk = sclk;
        prev_busy = busy;
      end
    end
  end

  initial begin
    logic prev_sclk1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_sclk1 = 1'b0;
      else begin
        if (sclk1 && !prev_sclk1) begin
          if (rise1_last >= 0) chk("div1_period", cyc - rise1_last, 2);
          rise1_last = cyc;
          if (exp1_bits.size() == 0) chk("div1_extra_bit", int'(mosi1), -1);
          else chk("div1_bit", int'(mosi1), exp1_bits.pop_front());
        end
        prev_sclk1 = sclk1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msg [4];
    logic [7:0] b;
    int         n;
    int         bad;
    msg = '{8'h48, 8'h69, 8'h21, 8'h0A};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_sclk", int'(sclk), 0);
    chk("reset_mosi", int'(mosi), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 'A': latency to first rise and total busy time
    rise_q.delete();
    send(8'h41);
    in_valid = 1'b0;
    wait_idle("single");
    chk("single_first_rise", (rise_q.size() > 0) ? rise_q[0] - last_acc : -1, 1 + CD);
    chk("single_busy_len", busy_fall - last_acc, 1 + 16 * CD);
    chk("single_rises", rise_q.size(), 8);

    // Burst "Hi!\n" back-to-back
    rise_q.delete();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      send(msg[i]);
      n += nw(msg[i]);
    end
    in_valid = 1'b0;
    wait_idle("burst");
    chk("burst_rises", rise_q.size(), 8 * n);
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] != 2 * CD) bad++;
    chk("burst_gaps", bad, 0);

    // Fill: 5 consecutive pushes leave 4 held, so the 6th sees backpressure
    for (int i = 0; i < 5; i++) send(8'($urandom));
    chk("fill_ready_low", int'(ready), 0);
    send(8'($urandom));
    in_valid = 1'b0;
    wait_idle("fill");

    // Reset in the middle of 0x55
    rise_q.delete();
    send(8'h55);
    in_valid = 1'b0;
    n = 0;
    while (rise_q.size() < 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_third_rise_seen", int'(rise_q.size() >= 3), 1);
    chk("pre_rst_sclk", int'(sclk), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_sclk", int'(sclk), 0);
    chk("rst_async_mosi", int'(mosi), 0);
    chk("rst_async_busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    send(8'h33);
    in_valid = 1'b0;
    wait_idle("post_rst");
    chk("post_rst_busy_len", busy_fall - last_acc, 1 + 16 * CD);

    // CLK_DIV=1 instance: 0xFF then 0x00
    for (int i = 0; i < 16; i++) exp1_bits.push_back(i < 8 ? 1 : 0);
    in1_valid = 1'b1;
    in1_data = 8'hFF;
    @(negedge clk);
    in1_data = 8'h00;
    @(negedge clk);
    in1_valid = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("div1_bits_left", exp1_bits.size(), 0);

    // Lone LF: one byte or CR+LF depending on build
    rise_q.delete();
    send(LF);
    in_valid = 1'b0;
    wait_idle("lf");
    chk("lf_busy_len", busy_fall - last_acc, 1 + 16 * CD * nw(LF));
    chk("lf_rises", rise_q.size(), 8 * nw(LF));

    // Randomized traffic with random gaps and backpressure
    for (int i = 0; i < 14; i++) begin
      b = ($urandom_range(0, 5) == 0) ? LF : 8'($urandom);
      send(b);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    wait_idle("random");
    chk("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
